// File: rtl/spi_vertex_pkg.sv
// spi_vertex_pkg: shared defaults, types and FSM state enum for the SPI
// vertex receiver.
//   DEF_WORD_W      default bits per component (Q4.12)
//   DEF_COMPONENTS  default words per vertex (x first)
//   word_t/vertex_t packed types at the default sizes
//   rx_state_e      receiver FSM states
//   cnt_w()         counter width helper, never returns 0
package spi_vertex_pkg;

  localparam int DEF_WORD_W     = 16;
  localparam int DEF_COMPONENTS = 4;

  typedef logic [DEF_WORD_W-1:0]                word_t;
  typedef logic [DEF_COMPONENTS*DEF_WORD_W-1:0] vertex_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_vertex_rx_if.sv
// spi_vertex_rx_if: SPI pins, vertex stream handshake and status of the
// vertex receiver.
//   io_spi_sclk/cs/mosi  SPI inputs (mode 0, cs active-low, MSB first)
//   io_spi_miso          SPI output (echo or tied low)
//   out_vertex/valid     head vertex of the receive FIFO
//   out_ready            consumer accepts the head vertex
//   rx_count             vertices accepted since reset
//   err_overflow/frame   sticky error flags, err_clear clears them
// Modports: slave = receiver side, master = host/consumer side.
interface spi_vertex_rx_if
  import spi_vertex_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int COMPONENTS = DEF_COMPONENTS
);

  logic                         io_spi_sclk;
  logic                         io_spi_cs;
  logic                         io_spi_mosi;
  logic                         io_spi_miso;
  logic [COMPONENTS*WORD_W-1:0] out_vertex;
  logic                         out_valid;
  logic                         out_ready;
  logic [15:0]                  rx_count;
  logic                         err_overflow;
  logic                         err_frame;
  logic                         err_clear;

  modport slave (
    input  io_spi_sclk, io_spi_cs, io_spi_mosi, out_ready, err_clear,
    output io_spi_miso, out_vertex, out_valid, rx_count, err_overflow, err_frame
  );

  modport master (
    output io_spi_sclk, io_spi_cs, io_spi_mosi, out_ready, err_clear,
    input  io_spi_miso, out_vertex, out_valid, rx_count, err_overflow, err_frame
  );

endinterface

// File: rtl/vertex_fifo.sv
// vertex_fifo: synchronous FIFO of whole vertices with a registered output.
//   clock, reset   system clock, async active-high reset
//   i_push, i_din  write request and data (ignored when full unless popping)
//   i_pop          read request (ignored when empty)
//   o_dout         head entry, valid while o_empty is low
//   o_full         DEPTH entries stored
//   o_empty        no head entry presented
// The head is presented one clock after it is written, and a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module vertex_fifo
  import spi_vertex_pkg::*;
#(
  parameter int WIDTH = DEF_COMPONENTS*DEF_WORD_W,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_dout;

  logic             w_pop;
  logic             w_push;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [AW:0]      w_count_left;

  assign o_full       = (r_count == (AW+1)'(DEPTH));
  assign o_empty      = ~r_valid;
  assign o_dout       = r_dout;
  assign w_pop        = i_pop & r_valid;
  assign w_push       = i_push & (~o_full | w_pop);
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  // Entries already stored that survive this cycle's pop; the entry being
  // written this cycle only becomes visible on the next clock.
  assign w_count_left = r_count - (AW+1)'(w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_dout   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_valid  <= (w_count_left != '0);
      if (w_count_left != '0) r_dout <= r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/spi_vertex_rx.sv
// spi_vertex_rx: SPI mode-0 slave that assembles fixed-point vertices into
// whole-vertex records and queues them for the geometry pipeline.
//   clock, reset  system clock (sclk <= clock/8), async active-high reset
//   bus (slave)   SPI pins, vertex stream valid/ready, rx_count, sticky
//                 err_overflow / err_frame with err_clear
// Optional build macro SPI_VERTEX_RX_ECHO_EN: miso echoes the previously
// completed word MSB first, changing on sclk falls; otherwise miso is 0.
//
// state | meaning
// IDLE  | cs high, counters held at zero
// SHIFT | cs low, sampling mosi on each sclk rise
module spi_vertex_rx
  import spi_vertex_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int COMPONENTS  = DEF_COMPONENTS,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic            clock,
  input logic            reset,
  spi_vertex_rx_if.slave bus
);

  localparam int VW  = WORD_W*COMPONENTS;
  localparam int BCW = cnt_w(WORD_W);
  localparam int WCW = cnt_w(COMPONENTS);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W-1);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(COMPONENTS-1);

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_rise;
  rx_state_e              r_state;
  rx_state_e              w_state_nxt;
  logic [BCW-1:0]         r_bit_cnt;
  logic [WCW-1:0]         r_word_cnt;
  logic [WORD_W-2:0]      r_word;
  logic [VW-1:0]          r_vertex;
  logic [15:0]            r_rx_count;
  logic                   r_err_ovf;
  logic                   r_err_frame;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_shift_en;
  logic                   w_abort;
  logic                   w_word_done;
  logic                   w_vertex_done;
  logic [WORD_W-1:0]      w_word_full;
  logic [VW-1:0]          w_vertex_full;
  logic [VW-1:0]          w_fifo_dout;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_pop;
  logic                   w_accept;
  logic                   w_drop;

  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // cs synchroniser resets to the deselected level so reset never opens a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_rise      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.io_spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.io_spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.io_spi_mosi};
      r_sclk_d    <= w_sclk_s;
      r_rise      <= w_sclk_s & ~r_sclk_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (!w_cs_s) w_state_nxt = SHIFT;
      SHIFT:   if (w_cs_s)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shift_en = 1'b0;
    w_abort    = 1'b0;
    if (r_state == SHIFT) begin
      if (w_cs_s) w_abort    = (r_bit_cnt != '0) || (r_word_cnt != '0);
      else        w_shift_en = r_rise;
    end
  end

  assign w_word_full   = {r_word, w_mosi_s};
  assign w_word_done   = w_shift_en && (r_bit_cnt == BIT_LAST);
  assign w_vertex_done = w_word_done && (r_word_cnt == WORD_LAST);

  // The last word goes straight into the pushed record, saving a clock.
  always_comb begin
    w_vertex_full = r_vertex;
    w_vertex_full[int'(r_word_cnt)*WORD_W +: WORD_W] = w_word_full;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_word     <= '0;
      r_vertex   <= '0;
    end else if (r_state != SHIFT || w_cs_s) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_word     <= '0;
    end else if (w_shift_en) begin
      r_word <= w_word_full[WORD_W-2:0];
      if (w_word_done) begin
        r_bit_cnt  <= '0;
        r_vertex   <= w_vertex_full;
        r_word_cnt <= (r_word_cnt == WORD_LAST) ? '0 : r_word_cnt + WCW'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
    end
  end

  assign w_pop    = ~w_fifo_empty & bus.out_ready;
  assign w_accept = w_vertex_done & (~w_fifo_full | w_pop);
  assign w_drop   = w_vertex_done & w_fifo_full & ~w_pop;

  vertex_fifo #(
    .WIDTH (VW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_vertex_done),
    .i_pop   (w_pop),
    .i_din   (w_vertex_full),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A set in the same cycle as err_clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_count  <= '0;
      r_err_ovf   <= 1'b0;
      r_err_frame <= 1'b0;
    end else begin
      if (w_accept) r_rx_count <= r_rx_count + 16'd1;
      if (w_drop)             r_err_ovf <= 1'b1;
      else if (bus.err_clear) r_err_ovf <= 1'b0;
      if (w_abort)            r_err_frame <= 1'b1;
      else if (bus.err_clear) r_err_frame <= 1'b0;
    end
  end

  assign bus.out_vertex   = w_fifo_dout;
  assign bus.out_valid    = ~w_fifo_empty;
  assign bus.rx_count     = r_rx_count;
  assign bus.err_overflow = r_err_ovf;
  assign bus.err_frame    = r_err_frame;

`ifdef SPI_VERTEX_RX_ECHO_EN
  logic              r_fall;
  logic [WORD_W-1:0] r_prev_word;
  logic [WORD_W-1:0] r_echo_sr;

  // A fall with bit_cnt at zero is the first fall after a word completed,
  // so the new echo word is loaded there; other falls shift it out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fall      <= 1'b0;
      r_prev_word <= '0;
      r_echo_sr   <= '0;
    end else begin
      r_fall <= ~w_sclk_s & r_sclk_d;
      if (r_state != SHIFT) begin
        r_prev_word <= '0;
        r_echo_sr   <= '0;
      end else begin
        if (w_word_done) r_prev_word <= w_word_full;
        if (r_fall) begin
          r_echo_sr <= (r_bit_cnt == '0) ? r_prev_word
                                         : {r_echo_sr[WORD_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.io_spi_miso = r_echo_sr[WORD_W-1];
`else
  assign bus.io_spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_vertex_rx.sv
module tb_spi_vertex_rx;

  localparam int WORD_W      = 16;
  localparam int COMPONENTS  = 4;
  localparam int DEPTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int VW          = WORD_W*COMPONENTS;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  spi_vertex_rx_if #(.WORD_W(WORD_W), .COMPONENTS(COMPONENTS)) bus ();

  spi_vertex_rx #(
    .WORD_W      (WORD_W),
    .COMPONENTS  (COMPONENTS),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a bounded queue of whole vertices plus counters/flags.
  logic [VW-1:0] exp_q[$];
  int            exp_count = 0;
  logic          exp_ovf   = 1'b0;
  logic          exp_frame = 1'b0;
  logic          miso_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_push(input logic [VW-1:0] v);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(v);
      exp_count = (exp_count + 1) % 65536;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.io_spi_mosi = b;
    wait_clks(5);
    miso_q.push_back(bus.io_spi_miso);
    bus.io_spi_sclk = 1'b1;
    wait_clks(5);
    bus.io_spi_sclk = 1'b0;
  endtask

  // mode 0: plain; 1: measure out_valid latency on the final rise;
  // 2: pop the head exactly on the cycle the final vertex is pushed.
  task automatic send_vertex(input logic [VW-1:0] v, input int mode);
    int lat;
    for (int k = 0; k < COMPONENTS; k++) begin
      for (int i = WORD_W-1; i >= 0; i--) begin
        if (k == COMPONENTS-1 && i == 0 && mode != 0) begin
          bus.io_spi_mosi = v[k*WORD_W + i];
          wait_clks(5);
          miso_q.push_back(bus.io_spi_miso);
          bus.io_spi_sclk = 1'b1;
          if (mode == 1) begin
            lat = 0;
            for (int n = 1; n <= 12; n++) begin
              @(posedge clock);
              #1;
              if (bus.out_valid && lat == 0) lat = n;
            end
            chk("valid_latency", 64'(lat), 64'(SYNC_STAGES+3));
            @(negedge clock);
          end else begin
            wait_clks(3);
            chk("full_valid", 64'(bus.out_valid), 64'(1));
            chk("full_head", bus.out_vertex, exp_q[0]);
            bus.out_ready = 1'b1;
            wait_clks(1);
            bus.out_ready = 1'b0;
            void'(exp_q.pop_front());
            wait_clks(1);
          end
          bus.io_spi_sclk = 1'b0;
        end else begin
          send_bit(v[k*WORD_W + i]);
        end
      end
    end
    model_push(v);
  endtask

  task automatic cs_begin();
    miso_q.delete();
    bus.io_spi_cs = 1'b0;
    wait_clks(6);
  endtask

  task automatic cs_end();
    wait_clks(6);
    bus.io_spi_cs = 1'b1;
    wait_clks(10);
  endtask

  task automatic pop_check(input string tag);
    int n;
    logic [VW-1:0] e;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
    chk(tag, bus.out_vertex, e);
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_rx_count"}, 64'(bus.rx_count), 64'(exp_count));
    chk({tag, "_err_overflow"}, 64'(bus.err_overflow), 64'(exp_ovf));
    chk({tag, "_err_frame"}, 64'(bus.err_frame), 64'(exp_frame));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_miso"}, 64'(bus.io_spi_miso), 64'(0));
    chk({tag, "_vertex"}, bus.out_vertex, 64'(0));
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_rx_count"}, 64'(bus.rx_count), 64'(0));
    chk({tag, "_err_overflow"}, 64'(bus.err_overflow), 64'(0));
    chk({tag, "_err_frame"}, 64'(bus.err_frame), 64'(0));
  endtask

  task automatic pulse_err_clear();
    bus.err_clear = 1'b1;
    wait_clks(1);
    bus.err_clear = 1'b0;
    wait_clks(1);
  endtask

  // Host-side view of the echo: each word as sampled just before the rises.
  task automatic echo_check();
    logic [WORD_W-1:0] e [COMPONENTS];
    for (int k = 0; k < COMPONENTS; k++) begin
      e[k] = '0;
      for (int i = 0; i < WORD_W; i++) e[k] = {e[k][WORD_W-2:0], miso_q[k*WORD_W + i]};
    end
`ifdef SPI_VERTEX_RX_ECHO_EN
    chk("echo_word0", 64'(e[0]), 64'h0);
    chk("echo_word1", 64'(e[1]), 64'hF800);
    chk("echo_word2", 64'(e[2]), 64'hF800);
`else
    chk("miso_tied", 64'(e[0] | e[1] | e[2] | e[3]), 64'h0);
`endif
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] square [4];

    bus.io_spi_sclk = 1'b0;
    bus.io_spi_cs   = 1'b1;
    bus.io_spi_mosi = 1'b0;
    bus.out_ready   = 1'b0;
    bus.err_clear   = 1'b0;
    reset = 1'b1;
    wait_clks(3);
    check_reset("reset");
    reset = 1'b0;
    wait_clks(3);

    // Single known vertex with latency and echo checks.
    cs_begin();
    send_vertex({16'h1000, 16'h0000, 16'hF800, 16'hF800}, 1);
    cs_end();
    check_flags("one_vertex");
    echo_check();
    pop_check("one_vertex_pop");
    chk("one_vertex_drained", 64'(bus.out_valid), 64'(0));

    // +-0.5 square, stored with the consumer stalled, then drained in order.
    square[0] = {16'h1000, 16'h0000, 16'hF800, 16'hF800};
    square[1] = {16'h1000, 16'h0000, 16'hF800, 16'h0800};
    square[2] = {16'h1000, 16'h0000, 16'h0800, 16'h0800};
    square[3] = {16'h1000, 16'h0000, 16'h0800, 16'hF800};
    cs_begin();
    for (int i = 0; i < 4; i++) send_vertex(square[i], 0);
    cs_end();
    check_flags("square");
    for (int i = 0; i < 4; i++) pop_check("square_pop");

    // DEPTH+1 random vertices: last one dropped.
    cs_begin();
    for (int i = 0; i < DEPTH+1; i++) begin
      v = {$urandom, $urandom};
      send_vertex(v, 0);
    end
    cs_end();
    check_flags("overflow");
    pulse_err_clear();
    exp_ovf = 1'b0;
    check_flags("overflow_cleared");
    while (exp_q.size() > 0) pop_check("overflow_pop");
    chk("overflow_drained", 64'(bus.out_valid), 64'(0));

    // Full FIFO with a pop on the very push cycle: push accepted.
    cs_begin();
    for (int i = 0; i < DEPTH; i++) begin
      v = {$urandom, $urandom};
      send_vertex(v, 0);
    end
    v = {$urandom, $urandom};
    send_vertex(v, 2);
    cs_end();
    check_flags("full_push_pop");
    while (exp_q.size() > 0) pop_check("full_push_pop_pop");

    // cs raised after 40 bits: partial frame discarded.
    cs_begin();
    for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
    cs_end();
    exp_frame = 1'b1;
    check_flags("frame_err");
    chk("frame_err_no_push", 64'(bus.out_valid), 64'(0));
    cs_begin();
    v = {$urandom, $urandom};
    send_vertex(v, 0);
    cs_end();
    check_flags("after_frame_err");
    pop_check("after_frame_err_pop");
    pulse_err_clear();
    exp_frame = 1'b0;
    check_flags("frame_err_cleared");

    // Reset mid-word (bit 7 of y) with a vertex waiting in the FIFO.
    cs_begin();
    v = {$urandom, $urandom};
    send_vertex(v, 0);
    v = {$urandom, $urandom};
    for (int i = 0; i < WORD_W + 8; i++) send_bit(v[(i / WORD_W)*WORD_W + (WORD_W-1 - (i % WORD_W))]);
    chk("pre_reset_valid", 64'(bus.out_valid), 64'(1));
    reset = 1'b1;
    #1;
    check_reset("async_reset");
    exp_q.delete();
    exp_count = 0;
    exp_ovf   = 1'b0;
    exp_frame = 1'b0;
    bus.io_spi_cs   = 1'b1;
    bus.io_spi_sclk = 1'b0;
    bus.io_spi_mosi = 1'b0;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(3);
    cs_begin();
    v = {$urandom, $urandom};
    send_vertex(v, 0);
    cs_end();
    check_flags("after_reset");
    pop_check("after_reset_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
